id_ex_forward: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS core.
- Captures decoded operands and control from ID each cycle, then drives the ALU operand/opcode inputs: EXA, EXB and EALUC (4-bit ALU code, same encoding the ALU decodes).
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, raising a one-cycle stall and inserting a bubble.

---
 rtl/id_ex_forward.sv | 106 ++++++++++
 tb/tb_id_ex_forward.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_forward.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall detection.
// Bubbles clear every write enable; operand fields still load but are don't-care.
module id_ex_forward #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DVALID,
    input  logic [3:0]    DALUC,
    input  logic [DW-1:0] DA,
    input  logic [DW-1:0] DB,
    input  logic [DW-1:0] DIMM,
    input  logic [RW-1:0] DRS,
    input  logic [RW-1:0] DRT,
    input  logic [RW-1:0] DRN,
    input  logic          DUSERT,
    input  logic          DALUSRC,
    input  logic          DWREG,
    input  logic          DM2REG,
    input  logic          DWMEM,
    input  logic          FLUSH,
    input  logic          MWREG,
    input  logic [RW-1:0] MRN,
    input  logic [DW-1:0] MALU,
    input  logic          WWREG,
    input  logic [RW-1:0] WRN,
    input  logic [DW-1:0] WDATA,
    output logic          LSTALL,
    output logic          EVALID,
    output logic          EWREG,
    output logic          EM2REG,
    output logic          EWMEM,
    output logic [3:0]    EALUC,
    output logic [RW-1:0] ERN,
    output logic [DW-1:0] EXA,
    output logic [DW-1:0] EXB,
    output logic [DW-1:0] EWDATA
);

    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] eimm;
    logic [RW-1:0] ers;
    logic [RW-1:0] ert;
    logic          ealusrc;
    logic          bubble;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // A load in EX whose result ID needs cannot be forwarded yet.
    assign LSTALL = EVALID & EM2REG & (ERN != '0) & DVALID &
                    ((ERN == DRS) | (DUSERT & (ERN == DRT)));

    assign bubble = LSTALL | FLUSH | ~DVALID;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVALID  <= 1'b0;
            EWREG   <= 1'b0;
            EM2REG  <= 1'b0;
            EWMEM   <= 1'b0;
            EALUC   <= 4'b0000;
            ERN     <= '0;
            ea      <= '0;
            eb      <= '0;
            eimm    <= '0;
            ers     <= '0;
            ert     <= '0;
            ealusrc <= 1'b0;
        end else begin
            EVALID  <= ~bubble;
            EWREG   <= ~bubble & DWREG;
            EM2REG  <= ~bubble & DM2REG;
            EWMEM   <= ~bubble & DWMEM;
            EALUC   <= DALUC;
            ERN     <= DRN;
            ea      <= DA;
            eb      <= DB;
            eimm    <= DIMM;
            ers     <= DRS;
            ert     <= DRT;
            ealusrc <= DALUSRC;
        end
    end

    // EX/MEM wins over MEM/WB; register 0 always reads its stored value.
    always_comb begin
        fwd_a = ea;
        if (MWREG && (MRN == ers) && (ers != '0))
            fwd_a = MALU;
        else if (WWREG && (WRN == ers) && (ers != '0))
            fwd_a = WDATA;

        fwd_b = eb;
        if (MWREG && (MRN == ert) && (ert != '0))
            fwd_b = MALU;
        else if (WWREG && (WRN == ert) && (ert != '0))
            fwd_b = WDATA;
    end

    assign EXA    = fwd_a;
    assign EXB    = ealusrc ? eimm : fwd_b;
    assign EWDATA = fwd_b;

endmodule

// File: tb/tb_id_ex_forward.sv
// Directed self-checking bench for id_ex_forward: reset, forwarding, load-use, immediate, flush.
module tb_id_ex_forward;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DVALID;
    logic [3:0]  DALUC;
    logic [31:0] DA, DB, DIMM;
    logic [4:0]  DRS, DRT, DRN;
    logic        DUSERT, DALUSRC, DWREG, DM2REG, DWMEM, FLUSH;
    logic        MWREG;
    logic [4:0]  MRN;
    logic [31:0] MALU;
    logic        WWREG;
    logic [4:0]  WRN;
    logic [31:0] WDATA;
    logic        LSTALL, EVALID, EWREG, EM2REG, EWMEM;
    logic [3:0]  EALUC;
    logic [4:0]  ERN;
    logic [31:0] EXA, EXB, EWDATA;

    int checks = 0;
    int errors = 0;

    id_ex_forward #(.DW(32), .RW(5)) dut (
        .CLK(CLK), .RST(RST), .DVALID(DVALID), .DALUC(DALUC), .DA(DA), .DB(DB),
        .DIMM(DIMM), .DRS(DRS), .DRT(DRT), .DRN(DRN), .DUSERT(DUSERT),
        .DALUSRC(DALUSRC), .DWREG(DWREG), .DM2REG(DM2REG), .DWMEM(DWMEM),
        .FLUSH(FLUSH), .MWREG(MWREG), .MRN(MRN), .MALU(MALU), .WWREG(WWREG),
        .WRN(WRN), .WDATA(WDATA), .LSTALL(LSTALL), .EVALID(EVALID), .EWREG(EWREG),
        .EM2REG(EM2REG), .EWMEM(EWMEM), .EALUC(EALUC), .ERN(ERN), .EXA(EXA),
        .EXB(EXB), .EWDATA(EWDATA)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        DVALID = 0; DALUC = 4'b0000; DA = '0; DB = '0; DIMM = '0;
        DRS = '0; DRT = '0; DRN = '0; DUSERT = 0; DALUSRC = 0;
        DWREG = 0; DM2REG = 0; DWMEM = 0; FLUSH = 0;
        MWREG = 0; MRN = '0; MALU = '0; WWREG = 0; WRN = '0; WDATA = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        #3;
        checks++; if (EVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_evalid got %b want 0", EVALID); end
        checks++; if (EALUC !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ealuc got %b want 0000", EALUC); end
        checks++; if ({EWREG, EM2REG, EWMEM} !== 3'b000) begin errors++; $display("[TB] FAIL reset_enables got %b want 000", {EWREG, EM2REG, EWMEM}); end
        checks++; if (LSTALL !== 1'b0) begin errors++; $display("[TB] FAIL reset_lstall got %b want 0", LSTALL); end
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DALUC = 4'b0010; DWREG = 1; DRN = 5'd9;
        step();
        checks++; if ({EVALID, EWREG, EALUC} !== {1'b1, 1'b1, 4'b0010}) begin errors++; $display("[TB] FAIL load_before_reset got %b want 110010", {EVALID, EWREG, EALUC}); end
        #2 RST = 1;
        #1;
        checks++; if ({EVALID, EWREG, EALUC, ERN} !== 11'd0) begin errors++; $display("[TB] FAIL async_reset got %b want 0", {EVALID, EWREG, EALUC, ERN}); end
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_raw_forward();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DRS = 5'd3; DA = 32'hDEAD; DWREG = 1; DRN = 5'd4;
        step();
        MWREG = 1; MRN = 5'd3; MALU = 32'h0000_0010;
        #1;
        checks++; if (EXA !== 32'h10) begin errors++; $display("[TB] FAIL raw_exmem got %h want 00000010", EXA); end
        MWREG = 0; WWREG = 1; WRN = 5'd3; WDATA = 32'h0000_0077;
        #1;
        checks++; if (EXA !== 32'h77) begin errors++; $display("[TB] FAIL raw_memwb got %h want 00000077", EXA); end
        WWREG = 0;
        #1;
        checks++; if (EXA !== 32'hDEAD) begin errors++; $display("[TB] FAIL raw_none got %h want 0000dead", EXA); end
    endtask

    task automatic test_double_hit();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DRT = 5'd5; DB = 32'hBBBB; DALUSRC = 0; DUSERT = 1;
        step();
        MWREG = 1; MRN = 5'd5; MALU = 32'h1; WWREG = 1; WRN = 5'd5; WDATA = 32'h2;
        #1;
        checks++; if (EXB !== 32'h1) begin errors++; $display("[TB] FAIL double_hit_exb got %h want 00000001", EXB); end
        checks++; if (EWDATA !== 32'h1) begin errors++; $display("[TB] FAIL double_hit_ewdata got %h want 00000001", EWDATA); end
        @(negedge CLK);
        DRT = 5'd0; DB = 32'h3333;
        MRN = 5'd0; WRN = 5'd0;
        step();
        checks++; if (EXB !== 32'h3333) begin errors++; $display("[TB] FAIL reg0_no_forward got %h want 00003333", EXB); end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DM2REG = 1; DWREG = 1; DRN = 5'd7; DRS = 5'd1;
        step();
        // Dependent instruction in ID; rt path not used so DRT match alone must not stall.
        DM2REG = 0; DRN = 5'd8; DRS = 5'd2; DRT = 5'd7; DUSERT = 0;
        #1;
        checks++; if (LSTALL !== 1'b0) begin errors++; $display("[TB] FAIL no_stall_unused_rt got %b want 0", LSTALL); end
        DRS = 5'd7; DA = 32'h1111; DRT = 5'd0;
        #1;
        checks++; if (LSTALL !== 1'b1) begin errors++; $display("[TB] FAIL load_use_stall got %b want 1", LSTALL); end
        step();
        checks++; if ({EVALID, EWREG, EM2REG} !== 3'b000) begin errors++; $display("[TB] FAIL stall_bubble got %b want 000", {EVALID, EWREG, EM2REG}); end
        checks++; if (LSTALL !== 1'b0) begin errors++; $display("[TB] FAIL stall_one_cycle got %b want 0", LSTALL); end
        step();
        WWREG = 1; WRN = 5'd7; WDATA = 32'hCAFE;
        #1;
        checks++; if (EXA !== 32'hCAFE) begin errors++; $display("[TB] FAIL reissue_exa got %h want 0000cafe", EXA); end
        checks++; if ({EVALID, EWREG, LSTALL} !== 3'b110) begin errors++; $display("[TB] FAIL reissue_ctrl got %b want 110", {EVALID, EWREG, LSTALL}); end
    endtask

    task automatic test_imm_store();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DALUSRC = 1; DIMM = 32'h0000_0080; DRT = 5'd4; DB = 32'h9999; DWMEM = 1;
        step();
        MWREG = 1; MRN = 5'd4; MALU = 32'h55;
        #1;
        checks++; if (EXB !== 32'h80) begin errors++; $display("[TB] FAIL imm_exb got %h want 00000080", EXB); end
        checks++; if (EWDATA !== 32'h55) begin errors++; $display("[TB] FAIL store_ewdata got %h want 00000055", EWDATA); end
        checks++; if (EWMEM !== 1'b1) begin errors++; $display("[TB] FAIL store_ewmem got %b want 1", EWMEM); end
    endtask

    task automatic test_flush();
        @(negedge CLK);
        clear_inputs();
        DVALID = 1; DWMEM = 1; DWREG = 1; FLUSH = 1;
        step();
        checks++; if ({EVALID, EWMEM, EWREG} !== 3'b000) begin errors++; $display("[TB] FAIL flush_bubble got %b want 000", {EVALID, EWMEM, EWREG}); end
        @(negedge CLK);
        FLUSH = 0; DVALID = 0;
        step();
        checks++; if ({EVALID, EWMEM, EWREG} !== 3'b000) begin errors++; $display("[TB] FAIL invalid_bubble got %b want 000", {EVALID, EWMEM, EWREG}); end
        @(negedge CLK);
        DVALID = 1;
        step();
        checks++; if ({EVALID, EWMEM, EWREG} !== 3'b111) begin errors++; $display("[TB] FAIL after_flush got %b want 111", {EVALID, EWMEM, EWREG}); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_raw_forward();
        test_double_hit();
        test_load_use();
        test_imm_store();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
